out_port_ctrl: RTL and testbench
================================

Name: out_port_ctrl

Overview:
Output-port unit executing the "out Ra" instruction: the control unit asserts OutPort_In while Ra drives the bus, and the word is captured into a small FIFO. Queued words are presented to an external consumer (display or peripheral) over a valid/ack handshake. Status flags let the control unit stall on Full and flag dropped writes. It sits on the datapath bus opposite the input port, which drives the bus through InPort_Out.

Parameters:
WIDTH, 32, data word width (equal to the bus width)
DEPTH, 4, FIFO entries; a power of two, 2..16
AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
Clock  input  1  system clock, rising edge
Clear  input  1  synchronous active-high reset
OutPort_In  input  1  write strobe from the control unit; capture BusMux_In at the rising edge
BusMux_In  input  WIDTH  datapath bus value (Ra contents)
Out_Data  output  WIDTH  head-of-FIFO word to the external device
Out_Valid  output  1  Out_Data holds a valid word
Out_Ack  input  1  external consumer accepts the word
Full  output  1  FIFO holds DEPTH entries
Empty  output  1  FIFO holds 0 entries
Level  output  AW+1  current entry count, 0..DEPTH
Overflow  output  1  sticky flag: at least one write was dropped

Behaviour:
- All state updates on the rising edge of Clock. Clear has priority over every other input.
- Clear sets:
  - rd_ptr, wr_ptr and Level to 0
  - Empty=1, Full=0, Out_Valid=0, Overflow=0
  - Out_Data=0; with OUT_PORT_HOLD_EN, the hold register is also 0
- Clear mid-transfer: queued words are discarded and no handshake completes in that cycle.
- Push rule: push = OutPort_In & (~Full | pop).
  - Writes BusMux_In to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop rule: pop = Out_Valid & Out_Ack.
  - rd_ptr increments modulo DEPTH.
  - Out_Ack while Out_Valid=0 is ignored and has no side effects.
- Dropped write: OutPort_In & Full & ~pop.
  - The word is discarded and storage is unchanged.
  - Overflow is set to 1 at the next edge and stays high until Clear.
- Level update:
  - +1 on push only, -1 on pop only.
  - Unchanged on push & pop together, or when neither occurs.
- Flags derive from registered Level:
  - Empty = (Level==0), Full = (Level==DEPTH), Out_Valid = ~Empty.
- Out_Data = mem[rd_ptr] whenever Out_Valid=1.
- Latency: push at edge N into an empty FIFO gives Out_Valid=1 and Out_Data = the word after edge N. There is no combinational path from BusMux_In to Out_Data.
- Simultaneous cases:
  - Full with push & pop in the same cycle: the write is accepted, Level stays DEPTH, and the next word appears after the edge.
  - Level==1 with push & pop: Level stays 1 and Out_Data advances to the new word.
  - Empty with OutPort_In & Out_Ack: no pop occurs because Out_Valid=0; the push proceeds.
- Pointer wrap-around: DEPTH is a power of two, so pointers wrap naturally. Level is the sole source of full/empty.
- Out_Data and Out_Valid are stable while Out_Valid=1 and Out_Ack=0; the consumer may hold off indefinitely.

Optional Feature:
OUT_PORT_HOLD_EN
- Defined:
  - A hold register captures mem[rd_ptr] on every pop.
  - When Empty=1, Out_Data drives the hold register, i.e. the last word consumed. This is for latched LED/7-segment outputs.
  - Out_Valid behaviour is unchanged.
- Undefined:
  - No hold register.
  - Out_Data = 0 whenever Empty=1.

Test Plan:
- Clear high for 2 cycles, then low -> Empty=1, Full=0, Level=0, Out_Valid=0, Overflow=0, Out_Data=0.
- Single out: OutPort_In=1 for one cycle with BusMux_In=0x000000A5, Out_Ack=0 ->
  - next cycle Out_Valid=1, Out_Data=0x000000A5, Level=1
  - Out_Valid and Out_Data hold for 5 idle cycles
  - Out_Ack=1 for one cycle -> Empty=1.
- Fill and overflow with DEPTH=4: push 0x11, 0x22, 0x33, 0x44 -> Full=1, Level=4. Push 0x55 with Out_Ack=0 -> Overflow=1, Level=4. Drain with Out_Ack=1 -> 0x11, 0x22, 0x33, 0x44 in order, then Empty.
- Full with simultaneous push & pop: FIFO holds 0x11..0x44, OutPort_In=1 with 0x66, Out_Ack=1 -> Level stays 4, Overflow=0. Drain order is 0x22, 0x33, 0x44, 0x66.
- Wrap and reset:
  - Stream 10 words 0x100..0x109 with Out_Ack continuously 1 -> every word is seen once, in order, with no overflow.
  - Then Clear asserted while Level=3 -> Empty=1 and Overflow=0 after the edge.
- Hold feature: pop 0xDEADBEEF until empty -> Out_Data=0xDEADBEEF with OUT_PORT_HOLD_EN defined; Out_Data=0 without it.

Source files
------------

// File: rtl/out_port_ctrl_if.sv
// Consumer-side handshake of the output port: head word, valid, ack.
// master drives data/valid, slave drives the acknowledge.
interface out_port_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] Out_Data;
  logic             Out_Valid;
  logic             Out_Ack;

  modport master (
    output Out_Data,
    output Out_Valid,
    input  Out_Ack
  );

  modport slave (
    input  Out_Data,
    input  Out_Valid,
    output Out_Ack
  );
endinterface

// File: rtl/out_port_ctrl.sv
// Output port for "out Ra": bus word -> FIFO -> valid/ack consumer.
// Optional OUT_PORT_HOLD_EN keeps the last consumed word on Out_Data.
module out_port_ctrl #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                OutPort_In,
  input  logic [WIDTH-1:0]    BusMux_In,
  out_port_ctrl_if.master     port,
  output logic                Full,
  output logic                Empty,
  output logic [AW:0]         Level,
  output logic                Overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      level;
  logic             ovf;
  logic             push;
  logic             pop;
  logic             empty;
  logic             full;
  logic [WIDTH-1:0] idle_data;

  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  assign pop   = ~empty & port.Out_Ack;
  assign push  = OutPort_In & (~full | pop);

  always_ff @(posedge Clock) begin
    if (Clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (OutPort_In & full & ~pop)
        ovf <= 1'b1;
    end
  end

  // Storage is not reset; Level alone decides what is valid.
  always_ff @(posedge Clock) begin
    if (push & ~Clear)
      mem[wr_ptr] <= BusMux_In;
  end

`ifdef OUT_PORT_HOLD_EN
  logic [WIDTH-1:0] hold;

  always_ff @(posedge Clock) begin
    if (Clear)
      hold <= '0;
    else if (pop)
      hold <= mem[rd_ptr];
  end

  assign idle_data = hold;
`else
  assign idle_data = '0;
`endif

  assign port.Out_Valid = ~empty;
  assign port.Out_Data  = empty ? idle_data : mem[rd_ptr];
  assign Full     = full;
  assign Empty    = empty;
  assign Level    = level;
  assign Overflow = ovf;

endmodule

// File: tb/tb_out_port_ctrl.sv
// Self-checking bench for out_port_ctrl against a queue reference model.
// Honours OUT_PORT_HOLD_EN for the idle Out_Data expectation.
module tb_out_port_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
`ifdef OUT_PORT_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic             Clock;
  logic             Clear;
  logic             OutPort_In;
  logic [WIDTH-1:0] BusMux_In;
  logic             Full;
  logic             Empty;
  logic [AW:0]      Level;
  logic             Overflow;

  out_port_ctrl_if #(.WIDTH(WIDTH)) port ();

  out_port_ctrl #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .Clock     (Clock),
    .Clear     (Clear),
    .OutPort_In(OutPort_In),
    .BusMux_In (BusMux_In),
    .port      (port),
    .Full      (Full),
    .Empty     (Empty),
    .Level     (Level),
    .Overflow  (Overflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] q [$];
  logic [31:0] seen [$];
  bit          m_ovf;
  logic [31:0] m_hold;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_data;
    int n;
    n = q.size();
    exp_data = (n != 0) ? q[0] : (HOLD ? m_hold : 32'h0);
    chk("level", 32'(Level), 32'(n));
    chk("empty", 32'(Empty), 32'(n == 0));
    chk("full", 32'(Full), 32'(n == DEPTH));
    chk("valid", 32'(port.Out_Valid), 32'(n != 0));
    chk("data", port.Out_Data, exp_data);
    chk("overflow", 32'(Overflow), 32'(m_ovf));
  endtask

  task automatic step(bit clr, bit wr, logic [31:0] d, bit ack);
    bit pop;
    bit push;
    Clear      = clr;
    OutPort_In = wr;
    BusMux_In  = d;
    port.Out_Ack = ack;
    if (!clr && ack && port.Out_Valid)
      seen.push_back(port.Out_Data);
    if (clr) begin
      q.delete();
      m_ovf  = 1'b0;
      m_hold = '0;
    end else begin
      pop  = (q.size() != 0) && ack;
      push = wr && ((q.size() < DEPTH) || pop);
      if (wr && !push)
        m_ovf = 1'b1;
      if (pop)
        m_hold = q.pop_front();
      if (push)
        q.push_back(d);
    end
    @(posedge Clock);
    #1;
    check_all();
  endtask

  initial begin
    Clear        = 1'b1;
    OutPort_In   = 1'b0;
    BusMux_In    = '0;
    port.Out_Ack = 1'b0;
    m_ovf        = 1'b0;
    m_hold       = '0;

    // reset
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_data", port.Out_Data, 32'h0);
    chk("rst_empty", 32'(Empty), 32'd1);

    // single out, held 5 idle cycles, then acked
    step(0, 1, 32'h0000_00A5, 0);
    chk("single_data", port.Out_Data, 32'h0000_00A5);
    chk("single_level", 32'(Level), 32'd1);
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 0);
    chk("single_hold", port.Out_Data, 32'h0000_00A5);
    step(0, 0, 0, 1);
    chk("single_popped", 32'(Empty), 32'd1);

    // fill, overflow, drain
    step(0, 1, 32'h11, 0);
    step(0, 1, 32'h22, 0);
    step(0, 1, 32'h33, 0);
    step(0, 1, 32'h44, 0);
    chk("fill_full", 32'(Full), 32'd1);
    step(0, 1, 32'h55, 0);
    chk("ovf_set", 32'(Overflow), 32'd1);
    chk("ovf_level", 32'(Level), 32'd4);
    seen.delete();
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 1);
    chk("drain_n", 32'(seen.size()), 32'd4);
    for (int i = 0; i < seen.size(); i++)
      chk("drain_word", seen[i], 32'h11 * (i + 1));
    chk("drain_empty", 32'(Empty), 32'd1);

    // full with push and pop together
    step(1, 0, 0, 0);
    step(0, 1, 32'h11, 0);
    step(0, 1, 32'h22, 0);
    step(0, 1, 32'h33, 0);
    step(0, 1, 32'h44, 0);
    step(0, 1, 32'h66, 1);
    chk("pp_level", 32'(Level), 32'd4);
    chk("pp_ovf", 32'(Overflow), 32'd0);
    seen.delete();
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 1);
    chk("pp_n", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk("pp_w0", seen[0], 32'h22);
      chk("pp_w1", seen[1], 32'h33);
      chk("pp_w2", seen[2], 32'h44);
      chk("pp_w3", seen[3], 32'h66);
    end

    // stream with continuous ack, pointers wrap
    seen.delete();
    for (int i = 0; i < 10; i++)
      step(0, 1, 32'h100 + i, 1);
    step(0, 0, 0, 1);
    chk("stream_n", 32'(seen.size()), 32'd10);
    for (int i = 0; i < seen.size(); i++)
      chk("stream_word", seen[i], 32'h100 + i);
    chk("stream_ovf", 32'(Overflow), 32'd0);

    // clear at level 3
    step(0, 1, 32'h7, 0);
    step(0, 1, 32'h8, 0);
    step(0, 1, 32'h9, 0);
    chk("pre_clr_level", 32'(Level), 32'd3);
    step(1, 1, 32'hA, 1);
    chk("clr_empty", 32'(Empty), 32'd1);
    chk("clr_ovf", 32'(Overflow), 32'd0);
    step(0, 0, 0, 0);

    // last-word hold
    step(0, 1, 32'hDEAD_BEEF, 0);
    step(0, 0, 0, 1);
    chk("hold_data", port.Out_Data, HOLD ? 32'hDEAD_BEEF : 32'h0);

    // empty with write and ack: push only
    step(0, 1, 32'h1234, 1);
    chk("empty_wr_ack", 32'(Level), 32'd1);

    // randomized traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
           $urandom, $urandom_range(0, 2) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
